// File: rtl/ssd_bcd_display.sv
// ssd_bcd_display: sequential shift-and-add-3 binary-to-BCD converter driving DIGITS active-low 7-segment displays.
// Define SSD_LEADING_ZERO_BLANK_EN to blank leading zero digits (digit 0 is always shown).
module ssd_bcd_display #(
    parameter int unsigned BIN_W  = 24,
    parameter int unsigned DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [BIN_W-1:0]    bin_in,
    output logic                in_ready,
    output logic [7*DIGITS-1:0] hex_out,
    output logic                done,
    output logic                overflow
);
    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(BIN_W - 1);
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t               state, state_next;
    logic [BIN_W-1:0]     bin_sr;
    logic [BCD_W-1:0]     bcd, bcd_adj;
    logic                 ovf_acc;
    logic [CNT_W-1:0]     cnt;
    logic [7*DIGITS-1:0]  seg_next;
    logic [3:0]           nib;
`ifdef SSD_LEADING_ZERO_BLANK_EN
    logic                 lead;
`endif

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = SEG_BLANK;
        endcase
    endfunction

    assign in_ready = (state == IDLE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = SHIFT;
            SHIFT:   if (cnt == LAST_SHIFT) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bcd_adj = bcd;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    // Walk digits from the most significant down so leading zeros can be tracked in one pass.
    always_comb begin
        seg_next = '1;
        nib      = '0;
`ifdef SSD_LEADING_ZERO_BLANK_EN
        lead     = 1'b1;
`endif
        for (int unsigned j = 0; j < DIGITS; j++) begin
            nib = bcd[4*(DIGITS-1-j) +: 4];
            if (ovf_acc) begin
                seg_next[7*(DIGITS-1-j) +: 7] = SEG_DASH;
`ifdef SSD_LEADING_ZERO_BLANK_EN
            end else if (lead && nib == 4'd0 && j != DIGITS - 1) begin
                seg_next[7*(DIGITS-1-j) +: 7] = SEG_BLANK;
            end else begin
                lead = 1'b0;
                seg_next[7*(DIGITS-1-j) +: 7] = seg7(nib);
`else
            end else begin
                seg_next[7*(DIGITS-1-j) +: 7] = seg7(nib);
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bin_sr   <= '0;
            bcd      <= '0;
            ovf_acc  <= 1'b0;
            cnt      <= '0;
            hex_out  <= '1;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        bin_sr  <= bin_in;
                        bcd     <= '0;
                        ovf_acc <= 1'b0;
                        cnt     <= '0;
                    end
                end
                SHIFT: begin
                    {bcd, bin_sr} <= {bcd_adj[BCD_W-2:0], bin_sr, 1'b0};
                    ovf_acc       <= ovf_acc | bcd_adj[BCD_W-1];
                    cnt           <= cnt + CNT_W'(1);
                end
                DONE: begin
                    hex_out  <= seg_next;
                    overflow <= ovf_acc;
                    done     <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ssd_bcd_display.sv
// tb_ssd_bcd_display: scoreboard bench for ssd_bcd_display at BIN_W=24/DIGITS=4 (dut_a) and BIN_W=10/DIGITS=3 (dut_b).
module tb_ssd_bcd_display;
    localparam logic [6:0] SEG_TAB [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        va = 1'b0, ra, donea, ovfa;
    logic [23:0] bina = '0;
    logic [27:0] hexa;
    logic        vb = 1'b0, rb, doneb, ovfb;
    logic [9:0]  binb = '0;
    logic [20:0] hexb;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_a = 0, acc_b = 0;
    int last_done_a = 0, prev_done_a = 0;
    bit busy_a = 0, busy_b = 0;

    typedef struct {
        logic [27:0] hex;
        logic        ovf;
        int          edge_n;
    } exp_t;
    exp_t sb_a[$];
    exp_t sb_b[$];

    ssd_bcd_display #(.BIN_W(24), .DIGITS(4)) dut_a (
        .clk(clk), .rst(rst), .in_valid(va), .bin_in(bina),
        .in_ready(ra), .hex_out(hexa), .done(donea), .overflow(ovfa)
    );

    ssd_bcd_display #(.BIN_W(10), .DIGITS(3)) dut_b (
        .clk(clk), .rst(rst), .in_valid(vb), .bin_in(binb),
        .in_ready(rb), .hex_out(hexb), .done(doneb), .overflow(ovfb)
    );

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [27:0] model_hex(input longint unsigned v, input int unsigned d, output logic ovf);
        longint unsigned p = 1;
        logic [27:0] h = '0;
        for (int unsigned i = 0; i < d; i++) p = p * 10;
        ovf = (v >= p);
        p = 1;
        for (int unsigned i = 0; i < d; i++) begin
            if (ovf) h[7*i +: 7] = 7'b0111111;
`ifdef SSD_LEADING_ZERO_BLANK_EN
            else if (i > 0 && v < p) h[7*i +: 7] = 7'b1111111;
`endif
            else h[7*i +: 7] = SEG_TAB[int'((v / p) % 10)];
            p = p * 10;
        end
        return h;
    endfunction

    // Scoreboard for dut_a: push on predicted accept edge, pop on done.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (busy_a && donea !== 1'b1) begin
                checks++;
                if (ra !== 1'b0) begin
                    errors++;
                    $display("FAIL ready_busy_a: in_ready=%b required 0 at edge %0d", ra, cyc);
                end
            end
            if (donea === 1'b1) begin
                checks++;
                if (sb_a.size() == 0) begin
                    errors++;
                    $display("FAIL done_a_unexpected: done=1 with no conversion pending, edge %0d", cyc);
                end else begin
                    e = sb_a.pop_front();
                    if (hexa !== e.hex) begin
                        errors++;
                        $display("FAIL hex_a: got %07h required %07h", hexa, e.hex);
                    end
                    checks++;
                    if (ovfa !== e.ovf) begin
                        errors++;
                        $display("FAIL ovf_a: got %b required %b", ovfa, e.ovf);
                    end
                    checks++;
                    if (cyc - e.edge_n != 25) begin
                        errors++;
                        $display("FAIL latency_a: got %0d edges required 25", cyc - e.edge_n);
                    end
                end
                busy_a = 0;
                prev_done_a = last_done_a;
                last_done_a = cyc;
            end
            if (va === 1'b1 && ra === 1'b1) begin
                e.hex = model_hex(longint'(bina), 4, e.ovf);
                e.edge_n = cyc + 1;
                sb_a.push_back(e);
                acc_a++;
                busy_a = 1;
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (busy_b && doneb !== 1'b1) begin
                checks++;
                if (rb !== 1'b0) begin
                    errors++;
                    $display("FAIL ready_busy_b: in_ready=%b required 0 at edge %0d", rb, cyc);
                end
            end
            if (doneb === 1'b1) begin
                checks++;
                if (sb_b.size() == 0) begin
                    errors++;
                    $display("FAIL done_b_unexpected: done=1 with no conversion pending, edge %0d", cyc);
                end else begin
                    e = sb_b.pop_front();
                    if (hexb !== e.hex[20:0]) begin
                        errors++;
                        $display("FAIL hex_b: got %06h required %06h", hexb, e.hex[20:0]);
                    end
                    checks++;
                    if (ovfb !== e.ovf) begin
                        errors++;
                        $display("FAIL ovf_b: got %b required %b", ovfb, e.ovf);
                    end
                    checks++;
                    if (cyc - e.edge_n != 11) begin
                        errors++;
                        $display("FAIL latency_b: got %0d edges required 11", cyc - e.edge_n);
                    end
                end
                busy_b = 0;
            end
            if (vb === 1'b1 && rb === 1'b1) begin
                e.hex = model_hex(longint'(binb), 3, e.ovf);
                e.edge_n = cyc + 1;
                sb_b.push_back(e);
                acc_b++;
                busy_b = 1;
            end
        end
    end

    task automatic wait_accept_a(input int target);
        for (int i = 0; i < 200 && acc_a < target; i++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (acc_a < target) begin
            errors++;
            $display("FAIL accept_a_timeout: accepts=%0d required %0d", acc_a, target);
        end
    endtask

    task automatic drain_a();
        for (int i = 0; i < 200 && sb_a.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (sb_a.size() != 0) begin
            errors++;
            $display("FAIL drain_a: %0d results pending required 0", sb_a.size());
            sb_a.delete();
            busy_a = 0;
        end
    endtask

    task automatic convert_a(input logic [23:0] v);
        int start = acc_a;
        va = 1'b1; bina = v;
        wait_accept_a(start + 1);
        va = 1'b0; bina = 24'($urandom);
        drain_a();
    endtask

    task automatic convert_b(input logic [9:0] v);
        int start = acc_b;
        vb = 1'b1; binb = v;
        for (int i = 0; i < 200 && acc_b == start; i++) begin
            @(posedge clk); #1;
        end
        vb = 1'b0; binb = 10'($urandom);
        for (int i = 0; i < 200 && sb_b.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (acc_b == start || sb_b.size() != 0) begin
            errors++;
            $display("FAIL convert_b_timeout: accepts=%0d pending=%0d", acc_b - start, sb_b.size());
            sb_b.delete();
            busy_b = 0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; va = 1'b1; vb = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (ra !== 1'b1 || donea !== 1'b0 || ovfa !== 1'b0 || hexa !== '1) begin
            errors++;
            $display("FAIL reset_a: ready=%b done=%b ovf=%b hex=%07h required 1 0 0 fffffff", ra, donea, ovfa, hexa);
        end
        checks++;
        if (rb !== 1'b1 || doneb !== 1'b0 || ovfb !== 1'b0 || hexb !== '1) begin
            errors++;
            $display("FAIL reset_b: ready=%b done=%b ovf=%b hex=%06h required 1 0 0 1fffff", rb, doneb, ovfb, hexb);
        end
        @(posedge clk); #1;
        rst = 1'b0; va = 1'b0; vb = 1'b0;
    endtask

    task automatic test_digits_347();
        logic [27:0] req;
        convert_a(24'd347);
`ifdef SSD_LEADING_ZERO_BLANK_EN
        req = {7'b1111111, 7'b0110000, 7'b0011001, 7'b1111000};
`else
        req = {7'b1000000, 7'b0110000, 7'b0011001, 7'b1111000};
`endif
        checks++;
        if (hexa !== req || ovfa !== 1'b0) begin
            errors++;
            $display("FAIL digits_347: hex=%07h ovf=%b required %07h 0", hexa, ovfa, req);
        end
    endtask

    task automatic test_values();
        logic [23:0] vals [12] = '{24'd9999, 24'd10000, 24'hFFFFFF, 24'd0, 24'd1, 24'd9,
                                   24'd10, 24'd99, 24'd100, 24'd1000, 24'd5555, 24'd8080};
        foreach (vals[i]) convert_a(vals[i]);
        checks++;
        if (ovfa !== 1'b0 || hexa[6:0] !== 7'b1000000) begin
            errors++;
            $display("FAIL hold_8080: ovf=%b digit0=%07b required 0 1000000", ovfa, hexa[6:0]);
        end
        for (int i = 0; i < 6; i++) convert_a(24'($urandom_range(0, 20000)));
    endtask

    task automatic test_back_to_back();
        int start = acc_a;
        va = 1'b1; bina = 24'd12;
        wait_accept_a(start + 1);
        bina = 24'd45;
        wait_accept_a(start + 2);
        va = 1'b0; bina = 24'($urandom);
        drain_a();
        checks++;
        if (last_done_a - prev_done_a != 26) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d cycles required 26", last_done_a - prev_done_a);
        end
    endtask

    task automatic test_reset_abort();
        int start = acc_a;
        va = 1'b1; bina = 24'd1234;
        wait_accept_a(start + 1);
        va = 1'b0; bina = 24'($urandom);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        sb_a.delete();
        busy_a = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (hexa !== '1 || ra !== 1'b1 || donea !== 1'b0 || ovfa !== 1'b0) begin
            errors++;
            $display("FAIL abort_state: hex=%07h ready=%b done=%b ovf=%b required fffffff 1 0 0", hexa, ra, donea, ovfa);
        end
        repeat (30) @(posedge clk);
        #1;
        convert_a(24'd500);
    endtask

    task automatic test_small_config();
        convert_b(10'd999);
        checks++;
        if (hexb !== {3{7'b0010000}} || ovfb !== 1'b0) begin
            errors++;
            $display("FAIL digits_b_999: hex=%06h ovf=%b required %06h 0", hexb, ovfb, {3{7'b0010000}});
        end
        convert_b(10'd1000);
        convert_b(10'd1023);
        convert_b(10'd0);
        convert_b(10'd123);
        convert_b(10'd70);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_digits_347();
        test_values();
        test_back_to_back();
        test_reset_abort();
        test_small_config();
        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ssd_bcd_display.md
# ssd_bcd_display

Parametrised sequential binary-to-BCD converter and multi-digit 7-segment driver for the reaction-timer display path. It accepts a binary value through a valid/ready handshake and converts it with an iterative shift-and-add-3 engine, one bit per clock. It then latches DIGITS active-low segment codes in a single update, so the displays never show partial results. Values too large for DIGITS decimal digits raise a sticky-per-result overflow flag and show dashes.

## Interface
- BIN_W, 24, width of binary input (≥1)
- DIGITS, 4, number of decimal digits / displays driven (≥1)
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- in_valid  in  1  bin_in holds a value to convert
- bin_in  in  BIN_W  unsigned binary value (ms)
- in_ready  out  1  converter idle; handshake completes when in_valid && in_ready
- hex_out  out  7*DIGITS  segment codes {g..a}, active-low; digit i (10^i) at [7i+6:7i]
- done  out  1  one-cycle pulse: hex_out/overflow just updated
- overflow  out  1  last converted value > 10^DIGITS − 1

## Operation
- States: IDLE, SHIFT, DONE. in_ready = (state == IDLE), combinational from state.
- IDLE: on in_valid && in_ready, capture bin_in into a shift register, clear the BCD accumulator (4*DIGITS bits), clear the overflow accumulator and the bit counter. Go to SHIFT.
- in_valid while not ready is ignored. bin_in changes after capture have no effect.
- SHIFT, each cycle:
  - Add 3 to every BCD nibble whose value is ≥5.
  - Shift {bcd, bin} left by one.
  - OR the bit shifted out of the top BCD nibble into the overflow accumulator.
  - Increment the counter. After BIN_W shifts, go to DONE.
- DONE, one cycle: register outputs and pulse done; return to IDLE.
  - overflow = overflow accumulator.
  - If overflow: every digit = dash, 7'b0111111.
  - Otherwise: each digit = seven-segment code of its nibble.
- Encoding, 0–9: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000. Any other nibble value → 1111111 (blank).
- hex_out and overflow hold their values between conversions.
- Counter width: $clog2(BIN_W+1). All arithmetic is unsigned. Nibble adds are confined to 4 bits.

## Timing
- Reset values: state IDLE, in_ready 1, done 0, overflow 0, hex_out all 1s (all blank). The shift register, accumulator and counter are cleared.
- Handshake accepted at edge k → SHIFT edges k+1..k+BIN_W → DONE edge k+BIN_W+1 updates hex_out/overflow. done is high for the cycle following that edge.
- Total latency BIN_W+1 edges from accept to output update.
- Throughput: one conversion per BIN_W+2 cycles. in_ready is high in the same cycle done is high, so a new accept may coincide with done.
- rst asserted mid-conversion: abort, no done pulse, outputs return to reset values next edge.
- rst has priority over a simultaneous handshake.

## Configuration
- SSD_LEADING_ZERO_BLANK_EN defined:
  - Digits above the most significant nonzero digit are blank (1111111).
  - Digit 0 is always displayed, so 0 shows a single "0".
  - Overflow dashes are unaffected.
- Not defined: all DIGITS digits are shown, including leading zeros.

## Test plan
- BIN_W=24, DIGITS=4, value 347 → done exactly 25 edges after the accept edge.
  - hex_out digits 3..0 = 1000000, 0110000, 0011001, 1111000; overflow 0.
  - With the macro defined, digit 3 = 1111111 instead.
- Value 9999 → all digits 0010000, overflow 0. Value 10000 → all digits 0111111, overflow 1. Value 0xFFFFFF → overflow 1.
- Value 0 → digits all 1000000. With the macro defined, only digit 0 = 1000000 and the others are 1111111.
- Hold in_valid high with 12 then 45 → in_ready low throughout each conversion.
  - Two done pulses, 26 cycles apart.
  - hex_out shows 0012 then 0045; bin_in changes during SHIFT are ignored.
- Assert rst for 1 cycle at SHIFT cycle 10 → no done pulse, hex_out = all 1s, in_ready = 1 the cycle after.
  - A subsequent conversion of 500 completes correctly.
- DIGITS=3, BIN_W=10, value 999 → 0010000 ×3, done 11 edges after accept. Value 1000 → overflow 1.
